// File: rtl/button_conditioner_pkg.sv
// Shared types and constants for the button conditioner: debounce FSM state
// encoding, button channel indices and the debounce counter width helper.
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    RELEASED  = 2'b00,
    ARMING    = 2'b01,
    PRESSED   = 2'b10,
    DISARMING = 2'b11
  } btn_state_e;

  localparam int BTN_A  = 2;
  localparam int BTN_B  = 1;
  localparam int BTN_OP = 0;

  // Counter must hold DEBOUNCE_CYCLES-1; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// One button channel: two-flop synchroniser, debounce FSM with stability
// counter, registered debounced level and single-cycle press strobe.
module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic i_button,
  output logic o_accept,
  output logic o_load_pulse,
  output logic o_btn_level
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_meta_q;
  logic          sync_q;
  btn_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;

  // Synchroniser, FSM state, counter and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_meta_q <= 1'b0;
      sync_q      <= 1'b0;
      state_q     <= RELEASED;
      cnt_q       <= CNT_ZERO;
      level_q     <= 1'b0;
      pulse_q     <= 1'b0;
    end else begin
      sync_meta_q <= i_button;
      sync_q      <= sync_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      pulse_q     <= pulse_d;
    end
  end

  // Next-state logic; a level change is accepted only after DEBOUNCE_CYCLES
  // consecutive agreeing synchronised samples.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    pulse_d = 1'b0;
    case (state_q)
      RELEASED: begin
        if (sync_q) begin
          state_d = ARMING;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      ARMING: begin
        if (!sync_q) begin
          state_d = RELEASED;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = CNT_ZERO;
          level_d = 1'b1;
          pulse_d = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!sync_q) begin
          state_d = DISARMING;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      DISARMING: begin
        if (sync_q) begin
          state_d = PRESSED;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RELEASED;
          cnt_d   = CNT_ZERO;
          level_d = 1'b0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = CNT_ZERO;
        level_d = 1'b0;
      end
    endcase
  end

  // o_accept is the pre-register strobe so the top can snapshot on the same edge.
  assign o_accept     = pulse_d;
  assign o_load_pulse = pulse_q;
  assign o_btn_level  = level_q;

endmodule

// File: rtl/button_conditioner.sv
// Input stage for the ALU top: debounced per-button load strobes plus a
// synchronised switch snapshot captured on the edge any strobe fires.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int N_BUTTONS       = 3,
  parameter int DATA_WIDTH      = 6,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N_BUTTONS-1:0]  i_buttons,
  input  logic [DATA_WIDTH-1:0] i_SWs,
  output logic [N_BUTTONS-1:0]  o_load_pulse,
  output logic [N_BUTTONS-1:0]  o_btn_level,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [N_BUTTONS-1:0]  accept_s;
  logic [DATA_WIDTH-1:0] sw_meta_q;
  logic [DATA_WIDTH-1:0] sw_sync_q;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  for (genvar g = 0; g < N_BUTTONS; g++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clock        (clock),
      .reset        (reset),
      .i_button     (i_buttons[g]),
      .o_accept     (accept_s[g]),
      .o_load_pulse (o_load_pulse[g]),
      .o_btn_level  (o_btn_level[g])
    );
  end

  // Switch synchroniser and snapshot register.
  always_ff @(posedge clock) begin
    if (reset) begin
      sw_meta_q <= {DATA_WIDTH{1'b0}};
      sw_sync_q <= {DATA_WIDTH{1'b0}};
      data_q    <= {DATA_WIDTH{1'b0}};
    end else begin
      sw_meta_q <= i_SWs;
      sw_sync_q <= sw_meta_q;
      data_q    <= data_d;
    end
  end

  // Simultaneous strobes share one snapshot; priority is left downstream.
  always_comb begin
    data_d = data_q;
    if (|accept_s) begin
      data_d = sw_sync_q;
    end else begin
      data_d = data_q;
    end
  end

  assign o_data = data_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: a run-length debounce model feeds a
// per-cycle scoreboard, plus explicit timing/count checks for each scenario.
module tb_button_conditioner;

  localparam int NB = 3;
  localparam int DW = 6;
  localparam int DC = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [NB-1:0] i_buttons;
  logic [DW-1:0] i_SWs;
  logic [NB-1:0] o_load_pulse;
  logic [NB-1:0] o_btn_level;
  logic [DW-1:0] o_data;

  button_conditioner #(
    .N_BUTTONS(NB), .DATA_WIDTH(DW), .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clock(clock), .reset(reset), .i_buttons(i_buttons), .i_SWs(i_SWs),
    .o_load_pulse(o_load_pulse), .o_btn_level(o_btn_level), .o_data(o_data)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [NB-1:0] pulse;
    logic [NB-1:0] level;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb_q[$];

  logic [NB-1:0] m_s1, m_s2, m_lvl, m_pulse;
  logic [DW-1:0] m_sw1, m_sw2, m_data;
  int            m_run[NB];

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            pcnt[NB];
  int            pcyc[NB];
  logic [DW-1:0] pdata[NB];
  int            r;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: a level flips once DC consecutive synchronised samples disagree with it.
  task automatic model_edge(input logic [NB-1:0] b, input logic [DW-1:0] sw, input logic rst);
    exp_t e;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pulse = '0;
      m_sw1 = '0; m_sw2 = '0; m_data = '0;
      for (int i = 0; i < NB; i++) m_run[i] = 0;
    end else begin
      m_pulse = '0;
      for (int i = 0; i < NB; i++) begin
        if (m_s2[i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == DC) begin
            m_lvl[i] = ~m_lvl[i];
            m_run[i] = 0;
            if (m_lvl[i]) m_pulse[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      if (|m_pulse) m_data = m_sw2;
      m_s2 = m_s1; m_s1 = b; m_sw2 = m_sw1; m_sw1 = sw;
    end
    e.pulse = m_pulse;
    e.level = m_lvl;
    e.data  = m_data;
    sb_q.push_back(e);
  endtask

  task automatic step(input logic [NB-1:0] b, input logic [DW-1:0] sw, input logic rst);
    exp_t e;
    i_buttons = b;
    i_SWs     = sw;
    reset     = rst;
    model_edge(b, sw, rst);
    @(posedge clock);
    #1;
    cyc++;
    e = sb_q.pop_front();
    check("sb_pulse", 32'(o_load_pulse), 32'(e.pulse));
    check("sb_level", 32'(o_btn_level), 32'(e.level));
    check("sb_data", 32'(o_data), 32'(e.data));
    for (int i = 0; i < NB; i++) begin
      if (o_load_pulse[i] === 1'b1) begin
        pcnt[i]++;
        pcyc[i]  = cyc;
        pdata[i] = o_data;
      end
    end
  endtask

  task automatic hold(input logic [NB-1:0] b, input logic [DW-1:0] sw, input logic rst, input int n);
    for (int k = 0; k < n; k++) step(b, sw, rst);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NB; i++) begin
      pcnt[i] = 0; pcyc[i] = -1; pdata[i] = '0;
    end
  endtask

  initial begin
    reset = 1'b1; i_buttons = '0; i_SWs = '0;
    clear_counts();

    // Reset state
    hold(3'b000, 6'b000000, 1'b1, 2);
    check("rst_pulse", 32'(o_load_pulse), 32'd0);
    check("rst_level", 32'(o_btn_level), 32'd0);
    check("rst_data", 32'(o_data), 32'd0);

    // 1. Basic load
    clear_counts();
    hold(3'b000, 6'b000011, 1'b0, 3);
    r = cyc + 1;
    hold(3'b100, 6'b000011, 1'b0, 20);
    check("t1_count", 32'(pcnt[2]), 32'd1);
    check("t1_when", 32'(pcyc[2]), 32'(r + 5));
    check("t1_data", 32'(pdata[2]), 32'(6'b000011));
    check("t1_level_held", 32'(o_btn_level[2]), 32'd1);
    hold(3'b000, 6'b000011, 1'b0, 10);
    check("t1_level_rel", 32'(o_btn_level[2]), 32'd0);

    // 2. Bounce rejection then steady press
    clear_counts();
    for (int k = 0; k < 6; k++) step((k % 2 == 0) ? 3'b010 : 3'b000, 6'b000011, 1'b0);
    hold(3'b000, 6'b000011, 1'b0, 6);
    check("t2_no_pulse", 32'(pcnt[1]), 32'd0);
    check("t2_level_low", 32'(o_btn_level[1]), 32'd0);
    r = cyc + 1;
    hold(3'b010, 6'b000011, 1'b0, 10);
    check("t2_count", 32'(pcnt[1]), 32'd1);
    check("t2_when", 32'(pcyc[1]), 32'(r + 5));
    hold(3'b000, 6'b000011, 1'b0, 10);

    // 3. Hold and re-press
    clear_counts();
    r = cyc + 1;
    hold(3'b001, 6'b100000, 1'b0, 30);
    check("t3_hold_count", 32'(pcnt[0]), 32'd1);
    check("t3_hold_when", 32'(pcyc[0]), 32'(r + 5));
    check("t3_hold_data", 32'(pdata[0]), 32'(6'b100000));
    hold(3'b000, 6'b100000, 1'b0, 2);
    hold(3'b001, 6'b100000, 1'b0, 10);
    check("t3_short_rel", 32'(pcnt[0]), 32'd1);
    check("t3_short_level", 32'(o_btn_level[0]), 32'd1);
    hold(3'b000, 6'b100000, 1'b0, 10);
    check("t3_rel_level", 32'(o_btn_level[0]), 32'd0);
    r = cyc + 1;
    hold(3'b001, 6'b100000, 1'b0, 10);
    check("t3_second_count", 32'(pcnt[0]), 32'd2);
    check("t3_second_when", 32'(pcyc[0]), 32'(r + 5));

    // 4. Snapshot stability
    hold(3'b001, 6'b000111, 1'b0, 10);
    check("t4_data_hold", 32'(o_data), 32'(6'b100000));
    hold(3'b000, 6'b000111, 1'b0, 10);
    check("t4_data_hold2", 32'(o_data), 32'(6'b100000));

    // 5. Simultaneous press
    clear_counts();
    hold(3'b000, 6'b000101, 1'b0, 3);
    r = cyc + 1;
    hold(3'b110, 6'b000101, 1'b0, 10);
    check("t5_count_a", 32'(pcnt[2]), 32'd1);
    check("t5_count_b", 32'(pcnt[1]), 32'd1);
    check("t5_count_op", 32'(pcnt[0]), 32'd0);
    check("t5_when_a", 32'(pcyc[2]), 32'(r + 5));
    check("t5_when_b", 32'(pcyc[1]), 32'(r + 5));
    check("t5_data", 32'(pdata[2]), 32'(6'b000101));
    hold(3'b000, 6'b000101, 1'b0, 10);

    // 6. Reset mid-debounce, button held through reset release
    clear_counts();
    hold(3'b100, 6'b101010, 1'b0, 3);
    step(3'b100, 6'b101010, 1'b1);
    check("t6_rst_pulse", 32'(o_load_pulse), 32'd0);
    check("t6_rst_level", 32'(o_btn_level), 32'd0);
    check("t6_rst_data", 32'(o_data), 32'd0);
    check("t6_no_early", 32'(pcnt[2]), 32'd0);
    r = cyc + 1;
    hold(3'b100, 6'b101010, 1'b0, 10);
    check("t6_count", 32'(pcnt[2]), 32'd1);
    check("t6_when", 32'(pcyc[2]), 32'(r + 5));
    check("t6_data", 32'(pdata[2]), 32'(6'b101010));
    hold(3'b000, 6'b101010, 1'b0, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
